// File: rtl/if_pc_gen.sv
// Instruction-fetch front end: owns the PC, addresses the synchronous ROM and pairs
// each returned instruction with its PC, with a one-entry hold buffer for stalls.
module if_pc_gen #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_i,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   output logic [31:0] rom_pc_o,
   input  logic [31:0] rom_inst_i,
   output logic [31:0] if_pc_o,
   output logic [31:0] if_inst_o,
   output logic        if_valid_o
);

   logic [31:0] fetch_pc_r;
   logic [31:0] resp_pc_r;
   logic        resp_valid_r;
   logic [31:0] hold_inst_r;
   logic        hold_valid_r;
   logic [31:0] inst_s;

   // PC, response and hold-buffer state; redirect beats stall, stall beats advance
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_r   <= RESET_PC;
         resp_pc_r    <= RESET_PC;
         resp_valid_r <= 1'b0;
         hold_inst_r  <= 32'h0000_0000;
         hold_valid_r <= 1'b0;
      end else if (jump_en_i) begin
         fetch_pc_r   <= {jump_addr_i[31:2], 2'b00};
         resp_valid_r <= 1'b0;
         hold_valid_r <= 1'b0;
      end else if (stall_i) begin
         // ROM data is only live on the first stalled cycle; later reads are discarded
         if (resp_valid_r && !hold_valid_r) begin
            hold_inst_r  <= rom_inst_i;
            hold_valid_r <= 1'b1;
         end else begin
            hold_valid_r <= hold_valid_r;
         end
      end else begin
         resp_pc_r    <= fetch_pc_r;
         resp_valid_r <= 1'b1;
         fetch_pc_r   <= fetch_pc_r + 32'd4;
         hold_valid_r <= 1'b0;
      end
   end

   // Instruction select: bubble, held instruction, or live ROM data
   always_comb begin
      inst_s = NOP_INST;
      if (!resp_valid_r) begin
         inst_s = NOP_INST;
      end else if (hold_valid_r) begin
         inst_s = hold_inst_r;
      end else begin
         inst_s = rom_inst_i;
      end
   end

   assign rom_pc_o   = fetch_pc_r;
   assign if_pc_o    = resp_pc_r;
   assign if_valid_o = resp_valid_r;
   assign if_inst_o  = inst_s;

endmodule
